cfg_bus_arbiter: RTL

CFG_BUS_ARBITER -- requirements
Module: cfg_bus_arbiter

---
 rtl/cfg_bus_arbiter_pkg.sv | 23 ++
 rtl/cfg_arb_pick.sv | 35 +++
 rtl/cfg_bus_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cfg_bus_arbiter_pkg.sv
// Shared definitions for the configuration-bus arbiter.
//   - arb_state_t : FSM state encoding (IDLE / ISSUE / CAPT)
//   - ADDR_W_DEF / DATA_W_DEF : default register address / data widths
//   - other_port() : the opposite requester id, used to advance the
//     round-robin pointer after a grant
// Build option: CFG_ARB_RR_EN selects round-robin arbitration (see
// cfg_arb_pick / cfg_bus_arbiter).
package cfg_bus_arbiter_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2
  } arb_state_t;

  function automatic logic other_port(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/cfg_arb_pick.sv
// Combinational winner select for the two-port configuration-bus arbiter.
// Ports:
//   req       in  [1:0] {m1_req, m0_req}
//   ptr       in  preferred port on a tie (only with CFG_ARB_RR_EN)
//   grant_vld out at least one request is pending
//   grant_id  out winning port id (meaningful only when grant_vld)
// Build option: CFG_ARB_RR_EN defined -> ties go to the port named by ptr;
// undefined -> port 0 always wins a tie and no pointer input exists.
module cfg_arb_pick
  import cfg_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
`ifdef CFG_ARB_RR_EN
  input  logic       ptr,
`endif
  output logic       grant_vld,
  output logic       grant_id
);

  always_comb begin
    grant_vld = |req;
    grant_id  = 1'b0;
`ifdef CFG_ARB_RR_EN
    if (req == 2'b11) begin
      grant_id = ptr;
    end else begin
      grant_id = req[1];
    end
`else
    // Port 0 wins whenever it is asking; otherwise port 1.
    grant_id = ~req[0];
`endif
  end

endmodule

// File: rtl/cfg_bus_arbiter.sv
// Two-requester arbiter onto a single-cycle register (cfg) bus.
// One transaction in flight: IDLE (arbitrate, latch command) -> ISSUE
// (reg_ce pulse) -> CAPT (capture read data, ack the winner) -> IDLE.
// Ports:
//   CLK, rst                       clock, asynchronous active-high reset
//   mX_req/we/addr/wdata           requester X command (X = 0 host, 1 sequencer)
//   mX_ack, mX_rdata               requester X completion pulse / read data
//   reg_ce/we/addr/wdata           registered register-bus command
//   reg_rdata                      register read data, valid the cycle after reg_ce
//   busy                           FSM not in IDLE
// Build option: CFG_ARB_RR_EN defined -> round-robin on simultaneous
// requests (pointer advances at every grant); undefined -> fixed priority
// with port 0 highest and no pointer state.
module cfg_bus_arbiter
  import cfg_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              reg_ce,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy
);

  arb_state_t        state_q, state_d;
  logic              win_q, win_d;
  logic              cmd_we_q, cmd_we_d;
  logic              reg_ce_q, reg_ce_d;
  logic              reg_we_q, reg_we_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m1_ack_q, m1_ack_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              grant_vld;
  logic              grant_id;

`ifdef CFG_ARB_RR_EN
  logic              ptr_q, ptr_d;

  cfg_arb_pick u_pick (
    .req       ({m1_req, m0_req}),
    .ptr       (ptr_q),
    .grant_vld (grant_vld),
    .grant_id  (grant_id)
  );
`else
  cfg_arb_pick u_pick (
    .req       ({m1_req, m0_req}),
    .grant_vld (grant_vld),
    .grant_id  (grant_id)
  );
`endif

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    cmd_we_d    = cmd_we_q;
    reg_ce_d    = 1'b0;
    reg_we_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    m0_ack_d    = 1'b0;
    m1_ack_d    = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
`ifdef CFG_ARB_RR_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          // The command goes straight into the bus registers so reg_ce
          // appears in the very next cycle; later input changes are ignored.
          state_d     = ISSUE;
          win_d       = grant_id;
          cmd_we_d    = grant_id ? m1_we : m0_we;
          reg_ce_d    = 1'b1;
          reg_we_d    = grant_id ? m1_we : m0_we;
          reg_addr_d  = grant_id ? m1_addr : m0_addr;
          reg_wdata_d = grant_id ? m1_wdata : m0_wdata;
`ifdef CFG_ARB_RR_EN
          ptr_d       = other_port(grant_id);
`endif
        end
      end
      ISSUE: begin
        // Ack is registered here so it is high during CAPT, the same cycle
        // in which reg_rdata is valid.
        state_d  = CAPT;
        m0_ack_d = ~win_q;
        m1_ack_d = win_q;
      end
      CAPT: begin
        state_d = IDLE;
        if (!cmd_we_q) begin
          if (win_q) begin
            m1_rdata_d = reg_rdata;
          end else begin
            m0_rdata_d = reg_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      win_q       <= 1'b0;
      cmd_we_q    <= 1'b0;
      reg_ce_q    <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
`ifdef CFG_ARB_RR_EN
      ptr_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      cmd_we_q    <= cmd_we_d;
      reg_ce_q    <= reg_ce_d;
      reg_we_q    <= reg_we_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      m0_ack_q    <= m0_ack_d;
      m1_ack_q    <= m1_ack_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
`ifdef CFG_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign reg_ce    = reg_ce_q;
  assign reg_we    = reg_we_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign busy      = (state_q != IDLE);

  // Read data is passed through during the ack cycle so it is valid together
  // with the ack; the register then holds it until the port's next read.
  assign m0_rdata = (m0_ack_q && !cmd_we_q) ? reg_rdata : m0_rdata_q;
  assign m1_rdata = (m1_ack_q && !cmd_we_q) ? reg_rdata : m1_rdata_q;

endmodule
